// File: rtl/l4_port_filter.sv
// l4_port_filter: matches (protocol, dst port) of each L4 header against a rule table; one pass/drop verdict per packet.
// Latency: verdict_valid 2 cycles after the sampled header edge, 1 cycle after a header-less end-of-packet.
// Backpressure: verdict held stable until verdict_ready; optional counters under L4_FILTER_CNT_EN.
module l4_port_filter #(
  parameter  int NUM_RULES = 8,
  localparam int IW        = $clog2(NUM_RULES + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [7:0]    protocol,
  input  logic          l4_hdr_ready,
  input  logic [15:0]   tcp_dst_port,
  input  logic [15:0]   udp_dst_port,
  input  logic          last_flag_in,
  input  logic          cfg_wr_en,
  input  logic [IW-1:0] cfg_addr,
  input  logic          cfg_valid,
  input  logic [7:0]    cfg_protocol,
  input  logic [15:0]   cfg_dst_port,
  input  logic          cfg_drop,
  input  logic          cfg_default_drop,
  output logic          verdict_valid,
  input  logic          verdict_ready,
  output logic          verdict_drop,
  output logic          verdict_hit,
  output logic [IW-1:0] verdict_rule,
  input  logic          cnt_clr,
  input  logic [IW-1:0] cnt_rd_addr,
  output logic [31:0]   cnt_rd_data
);

  localparam logic [IW-1:0] MISS_IDX = IW'(NUM_RULES);

  typedef struct packed {
    logic        valid;
    logic [7:0]  protocol;
    logic [15:0] dst_port;
    logic        drop;
  } rule_t;

  typedef enum logic [1:0] {IDLE, MATCH, HOLD, WAIT_LAST} state_t;

  state_t        state_q, state_d;
  rule_t         table_q [NUM_RULES];
  logic          hdr_rdy_q;
  logic          last_seen_q, last_seen_d;
  logic [7:0]    cap_proto_q;
  logic [15:0]   cap_port_q;
  logic [15:0]   sel_port;
  logic          hdr_rise;
  logic          capture, load_match, load_miss;
  logic          m_hit, m_drop;
  logic [IW-1:0] m_rule;
  logic          handshake;

  assign hdr_rise      = l4_hdr_ready & ~hdr_rdy_q;
  assign verdict_valid = (state_q == HOLD);
  assign handshake     = verdict_valid & verdict_ready;

  always_comb begin
    sel_port = 16'd0;
    if (protocol == 8'd6)       sel_port = tcp_dst_port;
    else if (protocol == 8'd17) sel_port = udp_dst_port;
  end

  // Descending scan so the lowest matching index is the one left standing.
  always_comb begin
    m_hit  = 1'b0;
    m_drop = cfg_default_drop;
    m_rule = MISS_IDX;
    for (int i = NUM_RULES - 1; i >= 0; i--) begin
      if (table_q[i].valid && (table_q[i].protocol == cap_proto_q) &&
          ((table_q[i].dst_port == cap_port_q) || (table_q[i].dst_port == 16'd0))) begin
        m_hit  = 1'b1;
        m_drop = table_q[i].drop;
        m_rule = IW'(i);
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    last_seen_d = last_seen_q;
    capture     = 1'b0;
    load_match  = 1'b0;
    load_miss   = 1'b0;
    case (state_q)
      IDLE: begin
        last_seen_d = 1'b0;
        if (hdr_rise) begin
          capture     = 1'b1;
          last_seen_d = last_flag_in;
          state_d     = MATCH;
        end else if (last_flag_in) begin
          // Packet ended without an L4 header: verdict is a miss and the last is already consumed.
          load_miss   = 1'b1;
          last_seen_d = 1'b1;
          state_d     = HOLD;
        end
      end
      MATCH: begin
        load_match = 1'b1;
        if (last_flag_in) last_seen_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        if (last_flag_in) last_seen_d = 1'b1;
        if (verdict_ready) begin
          last_seen_d = 1'b0;
          state_d     = (last_seen_q || last_flag_in) ? IDLE : WAIT_LAST;
        end
      end
      WAIT_LAST: begin
        if (last_flag_in) begin
          last_seen_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      hdr_rdy_q    <= 1'b0;
      last_seen_q  <= 1'b0;
      cap_proto_q  <= 8'd0;
      cap_port_q   <= 16'd0;
      verdict_drop <= 1'b0;
      verdict_hit  <= 1'b0;
      verdict_rule <= '0;
    end else begin
      state_q     <= state_d;
      hdr_rdy_q   <= l4_hdr_ready;
      last_seen_q <= last_seen_d;
      if (capture) begin
        cap_proto_q <= protocol;
        cap_port_q  <= sel_port;
      end
      if (load_match) begin
        verdict_drop <= m_drop;
        verdict_hit  <= m_hit;
        verdict_rule <= m_rule;
      end else if (load_miss) begin
        verdict_drop <= cfg_default_drop;
        verdict_hit  <= 1'b0;
        verdict_rule <= MISS_IDX;
      end
    end
  end

  // Writes land at the clock edge that closes MATCH, so the in-flight lookup sees the old entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_RULES; i++) table_q[i] <= '0;
    end else begin
      for (int i = 0; i < NUM_RULES; i++) begin
        if (cfg_wr_en && (cfg_addr == IW'(i))) begin
          table_q[i] <= '{valid: cfg_valid, protocol: cfg_protocol,
                          dst_port: cfg_dst_port, drop: cfg_drop};
        end
      end
    end
  end

`ifdef L4_FILTER_CNT_EN
  logic [31:0] cnt_q [NUM_RULES + 1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i <= NUM_RULES; i++) cnt_q[i] <= 32'd0;
    end else if (cnt_clr) begin
      for (int i = 0; i <= NUM_RULES; i++) cnt_q[i] <= 32'd0;
    end else if (handshake) begin
      for (int i = 0; i <= NUM_RULES; i++) begin
        if ((verdict_rule == IW'(i)) && (cnt_q[i] != 32'hFFFF_FFFF)) cnt_q[i] <= cnt_q[i] + 32'd1;
      end
    end
  end

  always_comb begin
    cnt_rd_data = 32'd0;
    for (int i = 0; i <= NUM_RULES; i++) begin
      if (cnt_rd_addr == IW'(i)) cnt_rd_data = cnt_q[i];
    end
  end
`else
  logic unused_cnt;
  assign unused_cnt  = ^{cnt_clr, cnt_rd_addr, handshake};
  assign cnt_rd_data = 32'd0;
`endif

endmodule

// File: tb/tb_l4_port_filter.sv
// Self-checking bench for l4_port_filter: directed scenarios plus randomized packets against a table-scan model.
module tb_l4_port_filter;
  localparam int NR = 8;
  localparam int IW = $clog2(NR + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic [7:0]    protocol;
  logic          l4_hdr_ready;
  logic [15:0]   tcp_dst_port, udp_dst_port;
  logic          last_flag_in;
  logic          cfg_wr_en;
  logic [IW-1:0] cfg_addr;
  logic          cfg_valid;
  logic [7:0]    cfg_protocol;
  logic [15:0]   cfg_dst_port;
  logic          cfg_drop, cfg_default_drop;
  logic          verdict_valid, verdict_ready, verdict_drop, verdict_hit;
  logic [IW-1:0] verdict_rule;
  logic          cnt_clr;
  logic [IW-1:0] cnt_rd_addr;
  logic [31:0]   cnt_rd_data;

  int errors = 0;
  int checks = 0;

  // Reference state: the rule table and per-rule/miss handshake counts.
  logic        m_valid [NR];
  logic [7:0]  m_proto [NR];
  logic [15:0] m_port  [NR];
  logic        m_drop  [NR];
  int unsigned m_cnt   [NR + 1];

  l4_port_filter #(.NUM_RULES(NR)) dut (
    .clk(clk), .rst_n(rst_n), .protocol(protocol), .l4_hdr_ready(l4_hdr_ready),
    .tcp_dst_port(tcp_dst_port), .udp_dst_port(udp_dst_port), .last_flag_in(last_flag_in),
    .cfg_wr_en(cfg_wr_en), .cfg_addr(cfg_addr), .cfg_valid(cfg_valid), .cfg_protocol(cfg_protocol),
    .cfg_dst_port(cfg_dst_port), .cfg_drop(cfg_drop), .cfg_default_drop(cfg_default_drop),
    .verdict_valid(verdict_valid), .verdict_ready(verdict_ready), .verdict_drop(verdict_drop),
    .verdict_hit(verdict_hit), .verdict_rule(verdict_rule), .cnt_clr(cnt_clr),
    .cnt_rd_addr(cnt_rd_addr), .cnt_rd_data(cnt_rd_data)
  );

  always #5 clk = ~clk;

  function automatic void ref_verdict(input logic [7:0] p, input logic [15:0] tp, input logic [15:0] up,
                                      input logic dd, output logic h, output logic [IW-1:0] r,
                                      output logic d);
    logic [15:0] port;
    port = (p == 8'd6) ? tp : ((p == 8'd17) ? up : 16'd0);
    h = 1'b0; r = IW'(NR); d = dd;
    for (int i = 0; i < NR; i++) begin
      if (!h && m_valid[i] && m_proto[i] == p && (m_port[i] == 16'd0 || m_port[i] == port)) begin
        h = 1'b1; r = IW'(i); d = m_drop[i];
      end
    end
  endfunction

  function automatic void model_clear();
    for (int i = 0; i < NR; i++) begin
      m_valid[i] = 1'b0; m_proto[i] = 8'd0; m_port[i] = 16'd0; m_drop[i] = 1'b0;
    end
    for (int i = 0; i <= NR; i++) m_cnt[i] = 0;
  endfunction

  function automatic logic [7:0] pick_proto();
    case ($urandom_range(0, 3))
      0: return 8'd6;
      1: return 8'd17;
      2: return 8'd1;
      default: return 8'($urandom);
    endcase
  endfunction

  function automatic logic [15:0] pick_port();
    case ($urandom_range(0, 4))
      0: return 16'd0;
      1: return 16'd53;
      2: return 16'd80;
      3: return 16'd443;
      default: return 16'($urandom);
    endcase
  endfunction

  task automatic cfg_write(input int idx, input logic v, input logic [7:0] p, input logic [15:0] port,
                           input logic d);
    @(negedge clk);
    cfg_wr_en = 1'b1; cfg_addr = IW'(idx); cfg_valid = v; cfg_protocol = p; cfg_dst_port = port; cfg_drop = d;
    @(negedge clk);
    cfg_wr_en = 1'b0;
    if (idx < NR) begin
      m_valid[idx] = v; m_proto[idx] = p; m_port[idx] = port; m_drop[idx] = d;
    end
  endtask

  // Drives one header edge; returns verdict_valid one and two cycles later plus the verdict fields.
  task automatic send_hdr(input logic [7:0] p, input logic [15:0] tp, input logic [15:0] up,
                          output logic v1, output logic v2, output logic h, output logic d,
                          output logic [IW-1:0] r);
    @(negedge clk);
    protocol = p; tcp_dst_port = tp; udp_dst_port = up; l4_hdr_ready = 1'b1;
    @(negedge clk);
    v1 = verdict_valid; l4_hdr_ready = 1'b0;
    @(negedge clk);
    v2 = verdict_valid; h = verdict_hit; d = verdict_drop; r = verdict_rule;
  endtask

  task automatic handshake(input logic last, input logic clr, input logic [IW-1:0] er, output logic va);
    verdict_ready = 1'b1; last_flag_in = last; cnt_clr = clr;
    @(negedge clk);
    verdict_ready = 1'b0; last_flag_in = 1'b0; cnt_clr = 1'b0;
    va = verdict_valid;
    if (clr) begin
      for (int i = 0; i <= NR; i++) m_cnt[i] = 0;
    end else begin
      m_cnt[er]++;
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; protocol = 8'd0; l4_hdr_ready = 1'b0; tcp_dst_port = 16'd0; udp_dst_port = 16'd0;
    last_flag_in = 1'b0; cfg_wr_en = 1'b0; cfg_addr = '0; cfg_valid = 1'b0; cfg_protocol = 8'd0;
    cfg_dst_port = 16'd0; cfg_drop = 1'b0; cfg_default_drop = 1'b0; verdict_ready = 1'b0;
    cnt_clr = 1'b0; cnt_rd_addr = '0;
    model_clear();
    repeat (3) @(negedge clk);
    checks++;
    if ({verdict_valid, verdict_hit, verdict_drop, verdict_rule} !== {3'b000, IW'(0)}) begin
      errors++;
      $display("FAIL reset_outputs: got v=%b h=%b d=%b r=%0d want all 0",
               verdict_valid, verdict_hit, verdict_drop, verdict_rule);
    end
    rst_n = 1'b1;
    @(negedge clk);
    cnt_rd_addr = IW'(NR); #1;
    checks++;
    if (cnt_rd_data !== 32'd0) begin
      errors++; $display("FAIL reset_cnt: got %0d want 0", cnt_rd_data);
    end
  endtask

  task automatic test_udp_hit;
    logic v1, v2, h, d, eh, ed, va;
    logic [IW-1:0] r, er;
    cfg_write(0, 1'b1, 8'd17, 16'd53, 1'b0);
    cfg_default_drop = 1'b1;
    ref_verdict(8'd17, 16'd999, 16'd53, 1'b1, eh, er, ed);
    send_hdr(8'd17, 16'd999, 16'd53, v1, v2, h, d, r);
    checks++;
    if ({v1, v2} !== 2'b01) begin
      errors++; $display("FAIL udp_latency: got v1=%b v2=%b want 0 1", v1, v2);
    end
    checks++;
    if ({h, d, r} !== {eh, ed, er}) begin
      errors++; $display("FAIL udp_verdict: got h=%b d=%b r=%0d want h=%b d=%b r=%0d", h, d, r, eh, ed, er);
    end
    handshake(1'b1, 1'b0, er, va);
    checks++;
    if (va !== 1'b0) begin
      errors++; $display("FAIL udp_release: got valid=%b want 0", va);
    end
  endtask

  task automatic test_wildcard_priority;
    logic v1, v2, h, d, eh, ed, va;
    logic [IW-1:0] r, er;
    cfg_write(1, 1'b1, 8'd6, 16'd0, 1'b1);
    cfg_write(2, 1'b1, 8'd6, 16'd80, 1'b0);
    cfg_default_drop = 1'b0;
    ref_verdict(8'd6, 16'd80, 16'd53, 1'b0, eh, er, ed);
    send_hdr(8'd6, 16'd80, 16'd53, v1, v2, h, d, r);
    checks++;
    if ({v2, h, d, r} !== {1'b1, eh, ed, er}) begin
      errors++; $display("FAIL wildcard_prio: got v=%b h=%b d=%b r=%0d want h=%b d=%b r=%0d", v2, h, d, r, eh, ed, er);
    end
    handshake(1'b1, 1'b0, er, va);
    ref_verdict(8'd17, 16'd53, 16'd54, 1'b0, eh, er, ed);
    send_hdr(8'd17, 16'd53, 16'd54, v1, v2, h, d, r);
    checks++;
    if ({v2, h, d, r} !== {1'b1, eh, ed, er}) begin
      errors++; $display("FAIL udp_port_miss: got v=%b h=%b d=%b r=%0d want h=%b d=%b r=%0d", v2, h, d, r, eh, ed, er);
    end
    handshake(1'b1, 1'b0, er, va);
  endtask

  task automatic test_no_header;
    logic v1, v2, h, d, va;
    logic [IW-1:0] r;
    for (int i = 0; i < NR; i++) cfg_write(i, 1'b0, 8'd0, 16'd0, 1'b0);
    cfg_default_drop = 1'b1;
    @(negedge clk);
    protocol = 8'd1; last_flag_in = 1'b1;
    @(negedge clk);
    last_flag_in = 1'b0;
    checks++;
    if ({verdict_valid, verdict_hit, verdict_drop, verdict_rule} !== {3'b101, IW'(NR)}) begin
      errors++;
      $display("FAIL nohdr_verdict: got v=%b h=%b d=%b r=%0d want v=1 h=0 d=1 r=%0d",
               verdict_valid, verdict_hit, verdict_drop, verdict_rule, NR);
    end
    handshake(1'b0, 1'b0, IW'(NR), va);
    checks++;
    if (va !== 1'b0) begin
      errors++; $display("FAIL nohdr_release: got valid=%b want 0", va);
    end
    send_hdr(8'd1, 16'd0, 16'd0, v1, v2, h, d, r);
    checks++;
    if ({v1, v2, h, d, r} !== {4'b0101, IW'(NR)}) begin
      errors++; $display("FAIL nohdr_back_idle: got v1=%b v2=%b h=%b d=%b r=%0d", v1, v2, h, d, r);
    end
    handshake(1'b1, 1'b0, IW'(NR), va);
  endtask

  task automatic test_backpressure;
    logic v1, v2, h, d, eh, ed, va;
    logic [IW-1:0] r, er;
    cfg_write(0, 1'b1, 8'd17, 16'd53, 1'b0);
    cfg_default_drop = 1'b1;
    ref_verdict(8'd17, 16'd0, 16'd53, 1'b1, eh, er, ed);
    send_hdr(8'd17, 16'd0, 16'd53, v1, v2, h, d, r);
    for (int i = 0; i < 5; i++) begin
      last_flag_in = (i == 1);
      @(negedge clk);
      last_flag_in = 1'b0;
      checks++;
      if ({verdict_valid, verdict_hit, verdict_drop, verdict_rule} !== {1'b1, eh, ed, er}) begin
        errors++;
        $display("FAIL hold_stable[%0d]: got v=%b h=%b d=%b r=%0d want v=1 h=%b d=%b r=%0d", i,
                 verdict_valid, verdict_hit, verdict_drop, verdict_rule, eh, ed, er);
      end
    end
    handshake(1'b0, 1'b0, er, va);
    send_hdr(8'd17, 16'd0, 16'd53, v1, v2, h, d, r);
    checks++;
    if ({va, v1, v2} !== 3'b001) begin
      errors++; $display("FAIL hold_last_idle: got va=%b v1=%b v2=%b want 0 0 1", va, v1, v2);
    end
    handshake(1'b1, 1'b0, er, va);
  endtask

  task automatic test_wait_last;
    logic v1, v2, h, d, eh, ed, va;
    logic [IW-1:0] r, er;
    ref_verdict(8'd17, 16'd0, 16'd53, cfg_default_drop, eh, er, ed);
    send_hdr(8'd17, 16'd0, 16'd53, v1, v2, h, d, r);
    handshake(1'b0, 1'b0, er, va);
    send_hdr(8'd17, 16'd0, 16'd53, v1, v2, h, d, r);
    @(negedge clk);
    checks++;
    if ({va, v1, v2, verdict_valid} !== 4'b0000) begin
      errors++; $display("FAIL waitlast_ignore_edge: got va=%b v1=%b v2=%b v3=%b want 0000", va, v1, v2, verdict_valid);
    end
    last_flag_in = 1'b1;
    @(negedge clk);
    last_flag_in = 1'b0;
    checks++;
    if (verdict_valid !== 1'b0) begin
      errors++; $display("FAIL waitlast_exit: got valid=%b want 0", verdict_valid);
    end
    send_hdr(8'd17, 16'd0, 16'd53, v1, v2, h, d, r);
    checks++;
    if ({v1, v2, h, d, r} !== {2'b01, eh, ed, er}) begin
      errors++; $display("FAIL waitlast_next_pkt: got v1=%b v2=%b h=%b d=%b r=%0d", v1, v2, h, d, r);
    end
    handshake(1'b1, 1'b0, er, va);
  endtask

  task automatic test_cfg_race;
    logic v1, v2, h, d, eh, ed, va;
    logic [IW-1:0] r, er;
    cfg_write(0, 1'b1, 8'd17, 16'd53, 1'b0);
    ref_verdict(8'd17, 16'd0, 16'd53, 1'b1, eh, er, ed);
    @(negedge clk);
    protocol = 8'd17; tcp_dst_port = 16'd0; udp_dst_port = 16'd53; l4_hdr_ready = 1'b1;
    @(negedge clk);
    l4_hdr_ready = 1'b0;
    cfg_wr_en = 1'b1; cfg_addr = '0; cfg_valid = 1'b1; cfg_protocol = 8'd17; cfg_dst_port = 16'd53; cfg_drop = 1'b1;
    @(negedge clk);
    cfg_wr_en = 1'b0;
    m_drop[0] = 1'b1;
    checks++;
    if ({verdict_valid, verdict_hit, verdict_drop, verdict_rule} !== {1'b1, eh, ed, er}) begin
      errors++; $display("FAIL cfg_race_old: got v=%b h=%b d=%b r=%0d want h=%b d=%b r=%0d",
                         verdict_valid, verdict_hit, verdict_drop, verdict_rule, eh, ed, er);
    end
    handshake(1'b1, 1'b0, er, va);
    ref_verdict(8'd17, 16'd0, 16'd53, 1'b1, eh, er, ed);
    send_hdr(8'd17, 16'd0, 16'd53, v1, v2, h, d, r);
    checks++;
    if ({v2, h, d, r} !== {1'b1, eh, ed, er}) begin
      errors++; $display("FAIL cfg_race_new: got v=%b h=%b d=%b r=%0d want h=%b d=%b r=%0d", v2, h, d, r, eh, ed, er);
    end
    handshake(1'b1, 1'b0, er, va);
  endtask

  task automatic test_random;
    logic v1, v2, h, d, eh, ed, va, nohdr;
    logic [IW-1:0] r, er;
    logic [7:0] p;
    logic [15:0] tp, up;
    for (int n = 0; n < 60; n++) begin
      if ($urandom_range(0, 1) == 1)
        cfg_write($urandom_range(0, (1 << IW) - 1), $urandom_range(0, 3) != 0, pick_proto(), pick_port(),
                  1'($urandom_range(0, 1)));
      cfg_default_drop = 1'($urandom_range(0, 1));
      p = pick_proto(); tp = pick_port(); up = pick_port();
      nohdr = ($urandom_range(0, 4) == 0);
      if (nohdr) begin
        @(negedge clk);
        protocol = p; last_flag_in = 1'b1;
        @(negedge clk);
        last_flag_in = 1'b0;
        v1 = 1'b0; v2 = verdict_valid; h = verdict_hit; d = verdict_drop; r = verdict_rule;
        eh = 1'b0; er = IW'(NR); ed = cfg_default_drop;
      end else begin
        ref_verdict(p, tp, up, cfg_default_drop, eh, er, ed);
        send_hdr(p, tp, up, v1, v2, h, d, r);
      end
      checks++;
      if ({v1, v2, h, d, r} !== {2'b01, eh, ed, er}) begin
        errors++;
        $display("FAIL random[%0d]: p=%0d tp=%0d up=%0d got v1=%b v2=%b h=%b d=%b r=%0d want h=%b d=%b r=%0d",
                 n, p, tp, up, v1, v2, h, d, r, eh, ed, er);
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
      handshake(!nohdr, 1'b0, er, va);
      checks++;
      if (va !== 1'b0) begin
        errors++; $display("FAIL random_release[%0d]: got valid=%b want 0", n, va);
      end
    end
  endtask

  task automatic test_counters;
    logic v1, v2, h, d, eh, ed, va;
    logic [IW-1:0] r, er;
`ifdef L4_FILTER_CNT_EN
    for (int i = 0; i <= NR; i++) begin
      cnt_rd_addr = IW'(i); #1;
      checks++;
      if (cnt_rd_data !== m_cnt[i]) begin
        errors++; $display("FAIL cnt_accum[%0d]: got %0d want %0d", i, cnt_rd_data, m_cnt[i]);
      end
    end
    cnt_clr = 1'b1;
    @(negedge clk);
    cnt_clr = 1'b0;
    for (int i = 0; i <= NR; i++) m_cnt[i] = 0;
    for (int i = 0; i < NR; i++) cfg_write(i, 1'b0, 8'd0, 16'd0, 1'b0);
    cfg_write(0, 1'b1, 8'd17, 16'd53, 1'b0);
    ref_verdict(8'd17, 16'd0, 16'd53, 1'b0, eh, er, ed);
    for (int k = 0; k < 3; k++) begin
      send_hdr(8'd17, 16'd0, 16'd53, v1, v2, h, d, r);
      handshake(1'b1, 1'b0, er, va);
    end
    cnt_rd_addr = '0; #1;
    checks++;
    if (cnt_rd_data !== m_cnt[0]) begin
      errors++; $display("FAIL cnt_three_hits: got %0d want %0d", cnt_rd_data, m_cnt[0]);
    end
    send_hdr(8'd17, 16'd0, 16'd53, v1, v2, h, d, r);
    handshake(1'b1, 1'b1, er, va);
    #1;
    checks++;
    if (cnt_rd_data !== m_cnt[0]) begin
      errors++; $display("FAIL cnt_clr_wins: got %0d want %0d", cnt_rd_data, m_cnt[0]);
    end
    for (int k = 0; k < 2; k++) begin
      ref_verdict(8'd6, 16'd22, 16'd0, 1'b0, eh, er, ed);
      send_hdr(8'd6, 16'd22, 16'd0, v1, v2, h, d, r);
      handshake(1'b1, 1'b0, er, va);
    end
    cnt_rd_addr = IW'(NR); #1;
    checks++;
    if (cnt_rd_data !== m_cnt[NR]) begin
      errors++; $display("FAIL cnt_miss: got %0d want %0d", cnt_rd_data, m_cnt[NR]);
    end
    cnt_rd_addr = IW'((1 << IW) - 1); #1;
    checks++;
    if (cnt_rd_data !== 32'd0) begin
      errors++; $display("FAIL cnt_out_of_range: got %0d want 0", cnt_rd_data);
    end
`else
    cfg_write(0, 1'b1, 8'd17, 16'd53, 1'b0);
    ref_verdict(8'd17, 16'd0, 16'd53, 1'b0, eh, er, ed);
    send_hdr(8'd17, 16'd0, 16'd53, v1, v2, h, d, r);
    handshake(1'b1, 1'b0, er, va);
    for (int i = 0; i <= NR; i++) begin
      cnt_rd_addr = IW'(i); #1;
      checks++;
      if (cnt_rd_data !== 32'd0) begin
        errors++; $display("FAIL cnt_disabled[%0d]: got %0d want 0", i, cnt_rd_data);
      end
    end
`endif
  endtask

  task automatic test_reset_mid;
    logic v1, v2, h, d, eh, ed, va;
    logic [IW-1:0] r, er;
    cfg_write(0, 1'b1, 8'd17, 16'd53, 1'b1);
    send_hdr(8'd17, 16'd0, 16'd53, v1, v2, h, d, r);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if ({verdict_valid, verdict_hit, verdict_drop, verdict_rule} !== {3'b000, IW'(0)}) begin
      errors++; $display("FAIL reset_mid_outputs: got v=%b h=%b d=%b r=%0d want all 0",
                         verdict_valid, verdict_hit, verdict_drop, verdict_rule);
    end
    rst_n = 1'b1;
    model_clear();
    cnt_rd_addr = '0; #1;
    checks++;
    if (cnt_rd_data !== 32'd0) begin
      errors++; $display("FAIL reset_mid_cnt: got %0d want 0", cnt_rd_data);
    end
    cfg_default_drop = 1'b0;
    ref_verdict(8'd17, 16'd0, 16'd53, 1'b0, eh, er, ed);
    send_hdr(8'd17, 16'd0, 16'd53, v1, v2, h, d, r);
    checks++;
    if ({v1, v2, h, d, r} !== {2'b01, eh, ed, er}) begin
      errors++; $display("FAIL reset_mid_table: got v1=%b v2=%b h=%b d=%b r=%0d want h=%b d=%b r=%0d",
                         v1, v2, h, d, r, eh, ed, er);
    end
    handshake(1'b1, 1'b0, er, va);
  endtask

  initial begin
    test_reset();
    test_udp_hit();
    test_wildcard_priority();
    test_no_header();
    test_backpressure();
    test_wait_last();
    test_cfg_race();
    test_random();
    test_counters();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
